uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver, the successor to the team's fixed-format receiver. Adds:
- configurable oversampling factor with 3-sample majority vote at bit centre;
- optional parity and 1 or 2 stop bits;
- false-start rejection and break detection;
- valid/ready output handshake with parity, framing and overrun error reporting.

Sits between the asynchronous serial pin and the byte-stream consumer (FIFO or command parser).

---
 rtl/uart_rx_os.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote at bit centre, optional parity,
// 1/2 stop bits, false-start rejection, break detection and a valid/ready output.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | validating start bit
//   DATA   | shifting in data bits, LSB first
//   PARITY | sampling parity bit
//   STOP   | sampling stop bit(s)
//   BREAK  | break seen, waiting for line to return high
module uart_rx_os #(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE     = 115_200,
   parameter int DATA_BITS     = 8,
   parameter int OVERSAMPLE    = 16,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 received_bit,
   output logic [DATA_BITS-1:0] processed_data,
   output logic                 processed_data_valid,
   input  logic                 processed_data_ready,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun_error,
   output logic                 break_detect
);
   localparam int TICK_DIV = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SMP_LO    = SW'(OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] SMP_MID   = SW'(OVERSAMPLE/2);
   localparam logic [SW-1:0] SMP_HI    = SW'(OVERSAMPLE/2 + 1);
   localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          ODD       = (PARITY == 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   if (TICK_DIV < 1) begin : g_div_check
      $error("uart_rx_os: CLK_FREQUENCY too low for BAUD_RATE*OVERSAMPLE");
   end

   logic                 rx_meta, rx_s;
   logic [TW-1:0]        tick_cnt;
   logic [SW-1:0]        samp_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [2:0]           state;
   logic [DATA_BITS-1:0] shift;
   logic                 s_lo, s_mid, par_bit, pe_pend, fe_pend;
   logic                 tick, resolve, bit_end, maj, par_calc;
   logic                 stop_done, fe_final, is_break, frame_ok;

   always_comb begin
      tick      = (tick_cnt == TICK_LAST);
      resolve   = tick && (samp_cnt == SMP_HI);
      bit_end   = tick && (samp_cnt == SMP_LAST);
      maj       = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
      par_calc  = (^shift) ^ ODD;
      stop_done = (state == ST_STOP) && resolve && (bit_cnt == STOP_LAST);
      fe_final  = fe_pend | ~maj;
      // A break looks like a frame of all zeros whose stop bit is also low.
      is_break  = stop_done && fe_final && (shift == '0) && ((PARITY == 0) || !par_bit);
      frame_ok  = stop_done && !is_break;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         tick_cnt <= '0;
         samp_cnt <= '0;
         bit_cnt  <= '0;
         state    <= ST_IDLE;
         shift    <= '0;
         s_lo     <= 1'b0;
         s_mid    <= 1'b0;
         par_bit  <= 1'b0;
         pe_pend  <= 1'b0;
         fe_pend  <= 1'b0;
      end else begin
         rx_meta  <= received_bit;
         rx_s     <= rx_meta;
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick) begin
            if (samp_cnt == SMP_LO)  s_lo  <= rx_s;
            if (samp_cnt == SMP_MID) s_mid <= rx_s;
            samp_cnt <= (samp_cnt == SMP_LAST) ? '0 : samp_cnt + 1'b1;
         end
         case (state)
            ST_IDLE: if (!rx_s) begin
               // Restart the bit timing so sampling is centred on this edge.
               state    <= ST_START;
               tick_cnt <= '0;
               samp_cnt <= '0;
               bit_cnt  <= '0;
               pe_pend  <= 1'b0;
               fe_pend  <= 1'b0;
            end
            ST_START: begin
               if (resolve && maj) state <= ST_IDLE;
               else if (bit_end)   state <= ST_DATA;
            end
            ST_DATA: begin
               if (resolve) shift <= {maj, shift[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (resolve) begin
                  par_bit <= maj;
                  if (maj != par_calc) pe_pend <= 1'b1;
               end
               if (bit_end) state <= ST_STOP;
            end
            ST_STOP: begin
               if (resolve) begin
                  if (!maj) fe_pend <= 1'b1;
                  if (bit_cnt == STOP_LAST) state <= is_break ? ST_BREAK : ST_IDLE;
               end else if (bit_end) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            ST_BREAK: if (rx_s) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         processed_data       <= '0;
         processed_data_valid <= 1'b0;
         parity_error         <= 1'b0;
         framing_error        <= 1'b0;
         overrun_error        <= 1'b0;
         break_detect         <= 1'b0;
      end else begin
         overrun_error <= 1'b0;
         break_detect  <= is_break;
         if (processed_data_valid && processed_data_ready) processed_data_valid <= 1'b0;
         if (frame_ok) begin
            if (!processed_data_valid || processed_data_ready) begin
               processed_data       <= shift;
               parity_error         <= pe_pend;
               framing_error        <= fe_final;
               processed_data_valid <= 1'b1;
            end else begin
               overrun_error <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and an 8E1 receiver driven with directed and random
// frames, compared against expectations computed from the frame contents.
module tb_uart_rx_os;
   localparam int BIT_CLKS = 160;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       n_line = 1'b1, n_ready = 1'b1;
   logic [7:0] n_data;
   logic       n_valid, n_pe, n_fe, n_ovr, n_brk;
   logic       e_line = 1'b1, e_ready = 1'b1;
   logic [7:0] e_data;
   logic       e_valid, e_pe, e_fe, e_ovr, e_brk;

   int tests = 0, fails = 0;
   int n_vcyc = 0, n_ovr_cnt = 0, n_brk_cnt = 0;
   int e_vcyc = 0, e_ovr_cnt = 0, e_brk_cnt = 0;
   logic [9:0] n_q[$];
   logic [9:0] e_q[$];

   uart_rx_os #(.CLK_FREQUENCY(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8),
                .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_n (
      .clk(clk), .reset(reset), .received_bit(n_line),
      .processed_data(n_data), .processed_data_valid(n_valid),
      .processed_data_ready(n_ready), .parity_error(n_pe), .framing_error(n_fe),
      .overrun_error(n_ovr), .break_detect(n_brk));

   uart_rx_os #(.CLK_FREQUENCY(1_600_000), .BAUD_RATE(10_000), .DATA_BITS(8),
                .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut_e (
      .clk(clk), .reset(reset), .received_bit(e_line),
      .processed_data(e_data), .processed_data_valid(e_valid),
      .processed_data_ready(e_ready), .parity_error(e_pe), .framing_error(e_fe),
      .overrun_error(e_ovr), .break_detect(e_brk));

   always #5 clk = ~clk;

   // Record accepted words and pulse counts away from the active edge.
   always @(negedge clk) begin
      if (n_valid) n_vcyc++;
      if (n_valid && n_ready) n_q.push_back({n_pe, n_fe, n_data});
      if (n_ovr) n_ovr_cnt++;
      if (n_brk) n_brk_cnt++;
      if (e_valid) e_vcyc++;
      if (e_valid && e_ready) e_q.push_back({e_pe, e_fe, e_data});
      if (e_ovr) e_ovr_cnt++;
      if (e_brk) e_brk_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit e, input logic v);
      if (e) e_line = v;
      else   n_line = v;
   endtask

   task automatic send_frame(input bit e, input logic [7:0] d, input logic p, input logic s);
      drive(e, 1'b0);
      clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         drive(e, d[i]);
         clks(BIT_CLKS);
      end
      if (e) begin
         drive(e, p);
         clks(BIT_CLKS);
      end
      drive(e, s);
      clks(BIT_CLKS);
      drive(e, 1'b1);
      clks(BIT_CLKS);
   endtask

   // Reference: parity/framing/break follow from the bits placed on the line.
   task automatic xfer(input string tag, input bit e, input logic [7:0] d,
                       input logic p, input logic s);
      int         brk0;
      logic       exp_pe, exp_fe, exp_brk;
      logic [9:0] w;
      brk0 = e ? e_brk_cnt : n_brk_cnt;
      send_frame(e, d, p, s);
      exp_fe  = !s;
      exp_pe  = e && (p != (($countones(d) % 2) == 1));
      exp_brk = (d == 8'h00) && (!e || !p) && exp_fe;
      chk({tag, ".brk"}, 32'((e ? e_brk_cnt : n_brk_cnt) - brk0), 32'(exp_brk));
      chk({tag, ".count"}, 32'(e ? e_q.size() : n_q.size()), exp_brk ? 32'd0 : 32'd1);
      if (!exp_brk) begin
         w = 'x;
         if (e && e_q.size() > 0) w = e_q.pop_front();
         else if (!e && n_q.size() > 0) w = n_q.pop_front();
         chk({tag, ".data"}, 32'(w[7:0]), 32'(d));
         chk({tag, ".pe"}, 32'(w[9]), 32'(exp_pe));
         chk({tag, ".fe"}, 32'(w[8]), 32'(exp_fe));
      end
      n_q.delete();
      e_q.delete();
   endtask

   initial begin
      int         v0, o0, b0;
      logic [7:0] d, d2;
      logic [7:0] d7e;
      logic       p, s, s2;
      logic [9:0] w;

      clks(5);
      chk("reset.n_valid", 32'(n_valid), 32'd0);
      chk("reset.n_data", 32'(n_data), 32'd0);
      chk("reset.n_flags", 32'({n_pe, n_fe, n_ovr, n_brk}), 32'd0);
      chk("reset.e_valid", 32'(e_valid), 32'd0);
      reset = 1'b0;
      clks(BIT_CLKS);

      v0 = n_vcyc;
      xfer("a5", 1'b0, 8'hA5, 1'b0, 1'b1);
      chk("a5.valid_cycles", 32'(n_vcyc - v0), 32'd1);

      xfer("par_bad", 1'b1, 8'h03, 1'b1, 1'b1);
      xfer("par_ok", 1'b1, 8'h03, 1'b0, 1'b1);

      n_line = 1'b0;
      clks(30);
      n_line = 1'b1;
      clks(2 * BIT_CLKS);
      chk("false_start.count", 32'(n_q.size()), 32'd0);
      chk("false_start.brk", 32'(n_brk_cnt), 32'd0);
      xfer("after_false", 1'b0, 8'h3C, 1'b0, 1'b1);

      xfer("fe55", 1'b0, 8'h55, 1'b0, 1'b0);

      n_ready = 1'b0;
      o0 = n_ovr_cnt;
      send_frame(1'b0, 8'h11, 1'b0, 1'b1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b1);
      chk("ovr.pulses", 32'(n_ovr_cnt - o0), 32'd1);
      chk("ovr.valid_held", 32'(n_valid), 32'd1);
      chk("ovr.data_held", 32'(n_data), 32'h11);
      chk("ovr.flags_held", 32'({n_pe, n_fe}), 32'd0);
      chk("ovr.none_accepted", 32'(n_q.size()), 32'd0);
      n_ready = 1'b1;
      clks(1);
      chk("ovr.valid_drop", 32'(n_valid), 32'd0);
      chk("ovr.accept_count", 32'(n_q.size()), 32'd1);
      w = 'x;
      if (n_q.size() > 0) w = n_q.pop_front();
      chk("ovr.accept_word", 32'(w), 32'h011);
      n_q.delete();

      b0 = n_brk_cnt;
      n_line = 1'b0;
      clks(12 * BIT_CLKS);
      n_line = 1'b1;
      clks(2 * BIT_CLKS);
      chk("break.pulses", 32'(n_brk_cnt - b0), 32'd1);
      chk("break.no_word", 32'(n_q.size()), 32'd0);

      // Hold a word on the parity receiver so the reset has something to clear.
      e_ready = 1'b0;
      send_frame(1'b1, 8'h5A, 1'b0, 1'b1);
      chk("pre_reset.e_valid", 32'(e_valid), 32'd1);
      d7e = 8'h7E;
      n_line = 1'b0;
      clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         n_line = d7e[i];
         clks(BIT_CLKS);
      end
      reset = 1'b1;
      #1;
      chk("midreset.e_valid", 32'(e_valid), 32'd0);
      chk("midreset.e_data", 32'(e_data), 32'd0);
      chk("midreset.n_valid", 32'(n_valid), 32'd0);
      chk("midreset.n_flags", 32'({n_pe, n_fe, n_ovr, n_brk}), 32'd0);
      n_line = 1'b1;
      e_ready = 1'b1;
      clks(3);
      reset = 1'b0;
      clks(2 * BIT_CLKS);
      chk("midreset.e_none", 32'(e_q.size()), 32'd0);
      xfer("after_reset", 1'b0, 8'h7E, 1'b0, 1'b1);

      for (int i = 0; i < 4; i++) begin
         d  = 8'($urandom_range(0, 255));
         d2 = 8'($urandom_range(0, 255));
         s  = ($urandom_range(0, 3) != 0);
         s2 = ($urandom_range(0, 3) != 0);
         p  = 1'($urandom_range(0, 1));
         xfer($sformatf("rnd_n%0d", i), 1'b0, d, 1'b0, s);
         xfer($sformatf("rnd_e%0d", i), 1'b1, d2, p, s2);
      end

      chk("e.no_overrun", 32'(e_ovr_cnt), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
